// File: rtl/ibuffer_burst_reader.sv
// Port-A burst read initiator for the input buffer: issues credit-limited
// reads and streams the responses to the consumer through a small FIFO.
// Ports: clk, rst (async, active high);
//   cmd_valid/ready, cmd_base, cmd_len_m1 and cmd_stride (IBUF_RD_STRIDE_EN only);
//   cen_a, wen_a, addr_a, last_a, ready_a (read requests);
//   rdata_a, rvalid_a, rlast_a, rready_a (read responses);
//   m_valid, m_ready, m_data, m_last (output stream); busy, done.
// Optional feature: `define IBUF_RD_STRIDE_EN adds cmd_stride; otherwise the address step is 1.
module ibuffer_burst_reader #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 128,
  parameter int LEN_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len_m1,
`ifdef IBUF_RD_STRIDE_EN
  input  logic [ADDR_W-1:0] cmd_stride,
`endif
  output logic              cen_a,
  output logic              wen_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic              last_a,
  input  logic              ready_a,
  input  logic [DATA_W-1:0] rdata_a,
  input  logic              rvalid_a,
  input  logic              rlast_a,
  output logic              rready_a,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] step;
  logic [LEN_W-1:0]  rem_q;
  logic [CW-1:0]     credits;

  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;

  logic cmd_fire, req_fire, m_fire, push;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign req_fire = cen_a && ready_a;
  assign m_fire   = m_valid && m_ready;
  // Credits reserve FIFO space per request, so a response is never refused.
  assign push     = rvalid_a;

  assign wen_a    = 1'b0;
  assign addr_a   = addr_q;
  assign rready_a = !rst;
  assign busy     = (state != IDLE);

  assign m_valid  = (count != '0);
  assign m_data   = m_valid ? mem[rptr][DATA_W-1:0] : '0;
  assign m_last   = m_valid && mem[rptr][DATA_W];

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    cen_a     = 1'b0;
    last_a    = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) state_nx = ISSUE;
      end
      ISSUE: begin
        cen_a  = (credits != '0);
        last_a = (rem_q == '0);
        if (cen_a && ready_a && last_a)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (m_fire && m_last) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      credits <= CW'(FIFO_DEPTH);
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
    end else begin
      state <= state_nx;
      if (cmd_fire) begin
        addr_q <= cmd_base;
        rem_q  <= cmd_len_m1;
      end else if (req_fire) begin
        addr_q <= addr_q + step;
        rem_q  <= rem_q - 1'b1;
      end
      unique case ({req_fire, m_fire})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
      if (push) wptr <= wptr + 1'b1;
      if (m_fire) rptr <= rptr + 1'b1;
      unique case ({push, m_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {rlast_a, rdata_a};
  end

`ifdef IBUF_RD_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;
  assign step = stride_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stride_q <= '0;
    else if (cmd_fire) stride_q <= cmd_stride;
  end
`else
  assign step = ADDR_W'(1);
`endif

endmodule

// File: tb/tb_ibuffer_burst_reader.sv
// Self-checking bench for ibuffer_burst_reader: random buffer latency,
// random handshakes, and an address/credit/beat model of the burst.
module tb_ibuffer_burst_reader;

  localparam int DEPTH = 4;

  logic         clk = 0;
  logic         rst = 0;
  logic         cmd_valid = 0;
  logic         cmd_ready;
  logic [14:0]  cmd_base = 0;
  logic [11:0]  cmd_len_m1 = 0;
`ifdef IBUF_RD_STRIDE_EN
  logic [14:0]  cmd_stride = 0;
`endif
  logic         cen_a, wen_a, last_a;
  logic [14:0]  addr_a;
  logic         ready_a = 0;
  logic [127:0] rdata_a = 0;
  logic         rvalid_a = 0;
  logic         rlast_a = 0;
  logic         rready_a;
  logic         m_valid, m_last;
  logic         m_ready = 0;
  logic [127:0] m_data;
  logic         busy, done;

  ibuffer_burst_reader dut (
    .clk(clk), .rst(rst),
    .cmd_valid(clk ? cmd_valid : cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len_m1(cmd_len_m1),
`ifdef IBUF_RD_STRIDE_EN
    .cmd_stride(cmd_stride),
`endif
    .cen_a(cen_a), .wen_a(wen_a), .addr_a(addr_a), .last_a(last_a),
    .ready_a(ready_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .rlast_a(rlast_a), .rready_a(rready_a),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  function automatic logic [127:0] mk_data(input logic [14:0] a);
    return {4{17'h1ABCD, a}};
  endfunction

  // burst model
  bit          active = 0, issuing = 0;
  int          req_idx = 0, out_idx = 0, resp_cnt = 0, mlen = 0;
  logic [14:0] mbase = 0, mstride = 0;
  int          done_cnt = 0, beat_cnt = 0;
  logic [14:0] req_log[$];
  logic [15:0] pend[$];
  int          r_mode = 1, m_mode = 1;

  function automatic logic [14:0] exp_addr(input int i);
    int v;
    v = (int'(mbase) + i * int'(mstride)) % 32768;
    return 15'(v);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctl", {cmd_ready, cen_a, wen_a, last_a, rready_a,
                      m_valid, m_last, busy, done}, 0);
      chk("rst_addr", addr_a, 0);
      chk("rst_data", m_data, 0);
      active = 0; issuing = 0;
      req_idx = 0; out_idx = 0; resp_cnt = 0;
    end else begin
      bit exp_cen, exp_mv, fin;
      exp_cen = issuing && ((req_idx - out_idx) < DEPTH);
      exp_mv  = (resp_cnt - out_idx) > 0;
      fin     = active && m_valid && m_ready && (out_idx == mlen);
      chk("cmd_ready", cmd_ready, !active);
      chk("busy", busy, active);
      chk("cen_a", cen_a, exp_cen);
      chk("wen_rready", {wen_a, rready_a}, 2'b01);
      if (cen_a && issuing) begin
        chk("addr_a", addr_a, exp_addr(req_idx));
        chk("last_a", last_a, req_idx == mlen);
      end
      chk("m_valid", m_valid, exp_mv);
      if (m_valid && active) begin
        chk("m_data", m_data, mk_data(exp_addr(out_idx)));
        chk("m_last", m_last, out_idx == mlen);
      end
      chk("done", done, fin);
      if (cen_a && ready_a && issuing) begin
        pend.push_back({last_a, addr_a});
        req_log.push_back(addr_a);
        if (req_idx == mlen) issuing = 0;
        req_idx++;
      end
      if (rvalid_a) resp_cnt++;
      if (m_valid && m_ready && active) begin
        out_idx++;
        beat_cnt++;
      end
      if (fin) begin
        active = 0;
        done_cnt++;
      end
      if (cmd_valid && cmd_ready) begin
        mbase = cmd_base;
        mlen  = int'(cmd_len_m1);
`ifdef IBUF_RD_STRIDE_EN
        mstride = cmd_stride;
`else
        mstride = 15'd1;
`endif
        active = 1; issuing = 1;
        req_idx = 0; out_idx = 0; resp_cnt = 0;
      end
    end
  end

  // buffer port-A responder and handshake drivers
  always @(posedge clk) begin
    logic [14:0] a;
    logic        l;
    #1;
    ready_a = (r_mode == 1) ? 1'b1 : 1'($urandom % 2);
    m_ready = (m_mode == 1) ? 1'b1 :
              (m_mode == 2) ? 1'b0 : 1'($urandom % 2);
    if (rst) begin
      pend.delete();
      rvalid_a = 0;
      rlast_a = 0;
    end else if (pend.size() > 0 && ($urandom % 2) == 1) begin
      {l, a} = pend.pop_front();
      rdata_a  = mk_data(a);
      rlast_a  = l;
      rvalid_a = 1;
    end else begin
      rvalid_a = 0;
      rlast_a  = 0;
      rdata_a  = 128'($urandom);
    end
  end

  task automatic send_cmd(input logic [14:0] b, input logic [11:0] l,
                          input logic [14:0] s);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_base = b; cmd_len_m1 = l;
`ifdef IBUF_RD_STRIDE_EN
    cmd_stride = s;
`else
    if (s != 0) n = 0;
`endif
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 50);
    if (!cmd_ready) chk("cmd_timeout", 1, 0);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (active && n < 3000);
    if (active) chk("burst_timeout", 1, 0);
  endtask

  task automatic run_burst(input logic [14:0] b, input logic [11:0] l,
                           input logic [14:0] s);
    req_log.delete();
    send_cmd(b, l, s);
    wait_idle();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 0;
  endtask

  initial begin
    int d0;
    logic [14:0] e1 [4];
    logic [14:0] e3 [4];
    e1 = '{15'h10, 15'h11, 15'h12, 15'h13};
    e3 = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    #2 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // basic 4-beat burst
    r_mode = 1; m_mode = 1;
    d0 = done_cnt; beat_cnt = 0;
    run_burst(15'h10, 12'd3, 15'd1);
    chk("t1_nreq", req_log.size(), 4);
    for (int i = 0; i < 4 && i < req_log.size(); i++)
      chk("t1_addr", req_log[i], e1[i]);
    chk("t1_beats", beat_cnt, 4);
    chk("t1_done", done_cnt - d0, 1);

    // credit limit with consumer stalled
    m_mode = 2; beat_cnt = 0;
    req_log.delete();
    send_cmd(15'h20, 12'd7, 15'd1);
    repeat (20) @(posedge clk);
    #2;
    chk("t2_nreq_stalled", req_log.size(), 4);
    chk("t2_cen_stalled", cen_a, 0);
    m_mode = 1;
    wait_idle();
    chk("t2_nreq", req_log.size(), 8);
    chk("t2_beats", beat_cnt, 8);

    // address wrap
    run_burst(15'h7FFE, 12'd3, 15'd1);
    chk("t3_nreq", req_log.size(), 4);
    for (int i = 0; i < 4 && i < req_log.size(); i++)
      chk("t3_addr", req_log[i], e3[i]);

    // stalled request port
    r_mode = 0; m_mode = 0;
    run_burst(15'h0300, 12'd5, 15'd1);
    chk("t4_nreq", req_log.size(), 6);
    for (int i = 0; i < 6 && i < req_log.size(); i++)
      chk("t4_addr", req_log[i], 15'(15'h0300 + i));

`ifdef IBUF_RD_STRIDE_EN
    r_mode = 1; m_mode = 1;
    run_burst(15'h100, 12'd2, 15'h40);
    chk("t5_nreq", req_log.size(), 3);
    if (req_log.size() == 3) begin
      chk("t5_a0", req_log[0], 15'h100);
      chk("t5_a1", req_log[1], 15'h140);
      chk("t5_a2", req_log[2], 15'h180);
    end
`endif

    // reset in the middle of a burst
    r_mode = 1; m_mode = 0;
    send_cmd(15'h0200, 12'd9, 15'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_busy_before_rst", busy, 1);
    do_reset();
    @(negedge clk);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_cen", cen_a, 0);
    m_mode = 1;
    run_burst(15'h0400, 12'd4, 15'd1);
    chk("t6_nreq", req_log.size(), 5);

    // random bursts
    for (int k = 0; k < 16; k++) begin
      r_mode = int'($urandom % 2);
      m_mode = int'($urandom % 2);
      run_burst(15'($urandom), 12'($urandom_range(0, 9)),
                15'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
